// File: rtl/song_sequencer.sv
// Song sequencer: records timestamped key events into an external RAM,
// then plays them back as a monophonic note stream against a 0.01 s tick.
//
// Ports:
//   clock, reset_n          system clock, async active-low reset
//   i_start, i_stop         one-cycle command pulses (stop wins)
//   i_mode_rec              1 = record, 0 = play (sampled with start)
//   i_ev_valid/i_ev_data    event offer {key[27:26], start[25:13], dur[12:0]}
//   o_ev_ready              event accepted when valid & ready
//   o_ram_addr/o_ram_wren/o_ram_wdata/i_ram_rdata
//                           synchronous RAM, 1-cycle read latency
//   o_song_time             elapsed ticks since start (saturating)
//   o_event_count           number of stored events
//   o_note_on/o_note_key    current note (key 00 = none)
//   o_busy, o_done, o_overflow  status
module song_sequencer #(
    parameter int TICK_DIV = 500000,
    parameter int ADDR_W   = 13
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_mode_rec,
    input  logic              i_ev_valid,
    input  logic [27:0]       i_ev_data,
    output logic              o_ev_ready,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_wren,
    output logic [27:0]       o_ram_wdata,
    input  logic [27:0]       i_ram_rdata,
    output logic [12:0]       o_song_time,
    output logic [ADDR_W-1:0] o_event_count,
    output logic              o_note_on,
    output logic [1:0]        o_note_key,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] PTR_FULL  = '1;
    localparam logic [12:0]       TIME_MAX  = 13'h1FFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECORD,
        S_FETCH,
        S_WAIT,
        S_SCHED,
        S_SOUND
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PW-1:0]     r_presc;
    logic [12:0]       r_song_time;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_event_count;
    logic              r_overflow;
    logic              r_done;
    logic [1:0]        r_ev_key;
    logic [12:0]       r_ev_start;
    logic [12:0]       r_ev_dur;
    logic [12:0]       r_remain;

    logic              w_tick;
    logic              w_start_acc;
    logic              w_ready;
    logic              w_hs;
    logic [ADDR_W-1:0] w_rd_next;
    logic              w_last;
    logic              w_adv;
    logic              w_sched_go;

    assign w_tick      = (r_presc == '0);
    assign w_start_acc = (r_state == S_IDLE) && i_start && !i_stop;
    assign w_ready     = (r_state == S_RECORD) && (r_wr_ptr != PTR_FULL);
    assign w_hs        = w_ready && i_ev_valid;
    assign w_rd_next   = r_rd_ptr + 1'b1;
    assign w_last      = (w_rd_next == r_event_count);

    // Leave the current event: empty slot in SCHED or finished note in SOUND.
    assign w_adv = !i_stop &&
                   (((r_state == S_SCHED) && (r_ev_key == 2'b00)) ||
                    ((r_state == S_SOUND) && (r_remain == '0)));

    assign w_sched_go = (r_state == S_SCHED) && (r_ev_key != 2'b00) &&
                        (r_song_time >= r_ev_start);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    if (i_mode_rec) begin
                        w_next = S_RECORD;
                    end else if (r_event_count != '0) begin
                        w_next = S_FETCH;
                    end
                end
            end
            S_RECORD: begin
                if (i_stop) w_next = S_IDLE;
            end
            S_FETCH: begin
                w_next = i_stop ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                w_next = i_stop ? S_IDLE : S_SCHED;
            end
            S_SCHED: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                end else if (w_adv) begin
                    w_next = w_last ? S_IDLE : S_FETCH;
                end else if (w_sched_go) begin
                    w_next = S_SOUND;
                end
            end
            S_SOUND: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                end else if (w_adv) begin
                    w_next = w_last ? S_IDLE : S_FETCH;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs derived from state; all fall to reset values with the state.
    always_comb begin
        o_ev_ready  = w_ready;
        o_ram_wren  = w_hs;
        o_ram_wdata = '0;
        o_ram_addr  = '0;
        o_note_on   = 1'b0;
        o_note_key  = 2'b00;
        o_busy      = (r_state != S_IDLE);
        unique case (r_state)
            S_RECORD: begin
                o_ram_addr  = r_wr_ptr;
                o_ram_wdata = i_ev_data;
            end
            S_FETCH: begin
                o_ram_addr = r_rd_ptr;
            end
            S_SOUND: begin
                // A zero-length note never raises note_on.
                o_note_on  = (r_remain != '0);
                o_note_key = (r_remain != '0) ? r_ev_key : 2'b00;
            end
            default: begin
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc       <= PRESC_MAX;
            r_song_time   <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_event_count <= '0;
            r_overflow    <= 1'b0;
            r_done        <= 1'b0;
            r_ev_key      <= 2'b00;
            r_ev_start    <= '0;
            r_ev_dur      <= '0;
            r_remain      <= '0;
        end else begin
            if (w_start_acc || w_tick) begin
                r_presc <= PRESC_MAX;
            end else begin
                r_presc <= r_presc - 1'b1;
            end

            if (w_start_acc) begin
                r_song_time <= '0;
            end else if (w_tick && (r_state != S_IDLE) &&
                         (r_song_time != TIME_MAX)) begin
                r_song_time <= r_song_time + 1'b1;
            end

            if (w_start_acc && i_mode_rec) begin
                r_wr_ptr      <= '0;
                r_event_count <= '0;
                r_overflow    <= 1'b0;
            end else if (w_hs) begin
                r_wr_ptr      <= r_wr_ptr + 1'b1;
                r_event_count <= r_event_count + 1'b1;
            end else if ((r_state == S_RECORD) && i_ev_valid) begin
                r_overflow <= 1'b1;
            end

            if (w_start_acc && !i_mode_rec) begin
                r_rd_ptr <= '0;
            end else if (w_adv && !w_last) begin
                r_rd_ptr <= w_rd_next;
            end

            if (r_state == S_WAIT) begin
                r_ev_key   <= i_ram_rdata[27:26];
                r_ev_start <= i_ram_rdata[25:13];
                r_ev_dur   <= i_ram_rdata[12:0];
            end

            if (w_sched_go) begin
                r_remain <= r_ev_dur;
            end else if ((r_state == S_SOUND) && w_tick &&
                         (r_remain != '0)) begin
                r_remain <= r_remain - 1'b1;
            end

            // Playback end, or play requested with nothing recorded.
            r_done <= (w_adv && w_last) ||
                      (w_start_acc && !i_mode_rec &&
                       (r_event_count == '0));
        end
    end

    assign o_song_time   = r_song_time;
    assign o_event_count = r_event_count;
    assign o_done        = r_done;
    assign o_overflow    = r_overflow;

endmodule
